// File: rtl/phys_reg_free_list_ckpt.sv
// Physical-register free list: circular FIFO of free tags, plus head-pointer
// checkpoint columns for single-cycle recovery after a branch mispredict.
module phys_reg_free_list_ckpt #(
    parameter int NUM_PHYS_REGS      = 64,
    parameter int NUM_ARCH_REGS      = 32,
    parameter int FREE_LIST_DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS,
    parameter int CHECKPOINT_COLUMNS = 4,
    localparam int TAG_W = $clog2(NUM_PHYS_REGS),
    localparam int PTR_W = $clog2(FREE_LIST_DEPTH) + 1,
    localparam int COL_W = $clog2(CHECKPOINT_COLUMNS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dequeue_valid,
    output logic             dequeue_ready,
    output logic [TAG_W-1:0] dequeue_tag,
    input  logic             enqueue_valid,
    input  logic [TAG_W-1:0] enqueue_tag,
    input  logic             save_valid,
    output logic             save_ready,
    output logic [COL_W-1:0] save_column,
    input  logic             clear_valid,
    input  logic [COL_W-1:0] clear_column,
    input  logic             restore_valid,
    input  logic [COL_W-1:0] restore_column,
    output logic [PTR_W-1:0] free_count,
    output logic             error
);

    localparam int IDX_W = PTR_W - 1;

    logic [TAG_W-1:0]              tag_mem [FREE_LIST_DEPTH];
    logic [PTR_W-1:0]              head;
    logic [PTR_W-1:0]              tail;
    logic [CHECKPOINT_COLUMNS-1:0] col_valid;
    logic [PTR_W-1:0]              col_head [CHECKPOINT_COLUMNS];
    logic [COL_W-1:0]              ckpt_tail;

    logic                          empty;
    logic                          full;
    logic                          restore_hit;
    logic                          do_dequeue;
    logic                          do_enqueue;
    logic                          do_save;
    logic                          err_event;
    logic [PTR_W-1:0]              head_after_deq;
    logic [COL_W-1:0]              restore_span;
    logic [CHECKPOINT_COLUMNS-1:0] kill_mask;
    logic [CHECKPOINT_COLUMNS-1:0] col_valid_next;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (head == tail);
    assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) &&
                   (head[PTR_W-1] != tail[PTR_W-1]);

    assign dequeue_ready = !empty;
    assign dequeue_tag   = tag_mem[head[IDX_W-1:0]];
    assign free_count    = tail - head;
    assign save_ready    = !col_valid[ckpt_tail];
    assign save_column   = ckpt_tail;

    // A successful restore squashes this cycle's dequeue and save silently.
    assign restore_hit    = restore_valid && col_valid[restore_column];
    assign do_dequeue     = dequeue_valid && !empty && !restore_hit;
    assign do_enqueue     = enqueue_valid && !full;
    assign do_save        = save_valid && save_ready && !restore_hit;
    assign head_after_deq = head + PTR_W'(do_dequeue);

    assign err_event = (dequeue_valid && empty && !restore_hit) ||
                       (enqueue_valid && full) ||
                       (save_valid && !save_ready && !restore_hit) ||
                       (restore_valid && !col_valid[restore_column]);

    // Columns from restore_column up to ckpt_tail-1 (circular) are younger;
    // a zero span means the ring wrapped, so every column is younger.
    assign restore_span = ckpt_tail - restore_column;

    for (genvar g = 0; g < CHECKPOINT_COLUMNS; g++) begin : g_kill
        assign kill_mask[g] = restore_hit &&
                              ((restore_span == '0) ||
                               ((COL_W'(g) - restore_column) < restore_span));
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        col_valid_next = col_valid;
        if (do_save) begin
            col_valid_next[ckpt_tail] = 1'b1;
        end
        col_valid_next = col_valid_next & ~kill_mask;
        if (clear_valid) begin
            col_valid_next[clear_column] = 1'b0;
        end
    end

    // NOTE: the tag array is reset because its post-reset contents (the
    // non-architectural tags) are functionally visible, unlike a plain RAM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
                tag_mem[i] <= TAG_W'(NUM_ARCH_REGS + i);
            end
        end else if (do_enqueue) begin
            tag_mem[tail[IDX_W-1:0]] <= enqueue_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head      <= '0;
            tail      <= PTR_W'(FREE_LIST_DEPTH);
            col_valid <= '0;
            ckpt_tail <= '0;
            error     <= 1'b0;
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                col_head[c] <= '0;
            end
        end else begin
            tail      <= tail + PTR_W'(do_enqueue);
            head      <= restore_hit ? col_head[restore_column] : head_after_deq;
            col_valid <= col_valid_next;
            error     <= error | err_event;
            if (do_save) begin
                col_head[ckpt_tail] <= head_after_deq;
            end
            if (restore_hit) begin
                ckpt_tail <= restore_column;
            end else if (do_save) begin
                ckpt_tail <= ckpt_tail + COL_W'(1);
            end
        end
    end

endmodule

// File: doc/phys_reg_free_list_ckpt.md
# phys_reg_free_list_ckpt

Parametrised physical-register free list with checkpoint save/restore. It supplies free physical register tags to rename (dispatch) and takes back freed tags at ROB commit. It also snapshots its head pointer into checkpoint columns at branch dispatch, so a mispredict recovers in one cycle without walking the ROB. It sits between the dispatch unit, the ROB and the BRU, and is the generalised successor to the fixed-size free list.

## Interface

Parameters:
- NUM_PHYS_REGS, 64: total physical registers.
- NUM_ARCH_REGS, 32: architectural registers, identity-mapped at reset.
- FREE_LIST_DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS: entries in the FIFO.
- CHECKPOINT_COLUMNS, 4: number of head-pointer snapshots.
- Derived widths: TAG_W = $clog2(NUM_PHYS_REGS); PTR_W = $clog2(FREE_LIST_DEPTH)+1 (extra wrap bit); COL_W = $clog2(CHECKPOINT_COLUMNS).

Ports:
- CLK  in  1  core clock.
- RST  in  1  asynchronous, active-high reset.
- dequeue_valid  in  1  rename consumes the head tag this cycle.
- dequeue_ready  out  1  list non-empty.
- dequeue_tag  out  TAG_W  tag at head (combinational from state).
- enqueue_valid  in  1  commit frees a tag.
- enqueue_tag  in  TAG_W  freed tag.
- save_valid  in  1  branch dispatch requests a checkpoint.
- save_ready  out  1  column at checkpoint tail is free.
- save_column  out  COL_W  column that will be allocated on save.
- clear_valid  in  1  branch resolved correct; release column.
- clear_column  in  COL_W  column to release.
- restore_valid  in  1  mispredict; roll back to column.
- restore_column  in  COL_W  column to restore.
- free_count  out  PTR_W  number of free tags.
- error  out  1  sticky protocol-violation flag.

## Operation

State:
- Circular tag array[FREE_LIST_DEPTH], head/tail pointers (PTR_W, wrap bit).
- Per column: valid bit, saved head pointer.
- Checkpoint tail pointer ckpt_tail (COL_W).

Reset:
- entry i = NUM_ARCH_REGS+i; head=0; tail=FREE_LIST_DEPTH (full).
- All columns invalid; ckpt_tail=0; error=0.
- Reset outputs: dequeue_ready=1, dequeue_tag=NUM_ARCH_REGS, free_count=FREE_LIST_DEPTH, save_ready=1, save_column=0.

Empty/full tests:
- empty: head==tail.
- full: index bits equal and wrap bits differ.
- free_count = tail-head, modulo 2^PTR_W.

Dequeue: when dequeue_valid and dequeue_ready, head+1. If dequeue_valid is asserted while empty, the request is ignored and error is set.

Enqueue: write enqueue_tag at tail, then tail+1. An enqueue while full is dropped and sets error. There is no empty-bypass: a tag enqueued in cycle N is dequeuable in cycle N+1.

Save: when save_valid and save_ready:
- column[ckpt_tail].valid=1;
- column[ckpt_tail].head = head after this cycle's dequeue, so a same-cycle dequeue is included;
- ckpt_tail+1.

A save while save_ready=0 is ignored and sets error.

Clear: column[clear_column].valid=0. Out-of-order clears are allowed. Allocation happens only at ckpt_tail, so a still-valid tail column stalls save_ready.

Restore, when restore_valid and the column is valid:
- head = column.head;
- invalidate the restored column and every younger column, i.e. those from restore_column up to ckpt_tail-1 circularly;
- ckpt_tail = restore_column.

Restore on an invalid column is ignored and sets error.

Priority when events coincide in one cycle:
- Restore overrides dequeue and save (both ignored, no error).
- Enqueue is always applied.
- A clear in the same cycle is applied after restore invalidation.

## Timing

- All state updates on posedge CLK. Reset is asynchronous on posedge RST, and the reset state is held while RST=1.
- dequeue_tag, dequeue_ready, save_ready, save_column and free_count are combinational from registered state; zero-latency read.
- Restore takes effect in 1 cycle: the cycle after restore_valid, dequeue_tag shows the entry at the restored head.
- free_count after restore = tail_new - saved_head. This includes tags enqueued since the save, which remain free.
- Pointer and column arithmetic wraps modulo its width. FREE_LIST_DEPTH must be a power of two.
- error is sticky until RST.

## Test plan

- Reset then 32 back-to-back dequeues:
  - tags 32..63 in order;
  - dequeue_ready=0 and free_count=0 after the 32nd;
  - a 33rd dequeue_valid sets error=1.
- Drain fully, then enqueue tag 40 in cycle N with dequeue_valid also high: no dequeue in N; in N+1 dequeue_tag=40 and dequeue_ready=1.
- From reset:
  - dequeue 3 (tags 32,33,34);
  - save with a same-cycle dequeue (tag 35); save_column=0, and the column holds head=4;
  - dequeue 2 more (36,37);
  - enqueue 34;
  - restore column 0 → next cycle dequeue_tag=36, free_count=29.
- Save four columns (0..3), then check:
  - save_ready=0;
  - clear 2 → save_ready stays 0, because the tail column 0 is still valid;
  - clear 0 → save_ready=1, save_column=0.
- With columns 0,1,2 valid and ckpt_tail=3, restore 1 with simultaneous save_valid and dequeue_valid:
  - columns 1 and 2 are invalidated; ckpt_tail=1;
  - the save and dequeue are ignored; error=0.
- Restore an invalid column → head unchanged, error=1. Assert RST mid-sequence → all outputs return to their reset values immediately.
